// File: rtl/game_link_ctl.sv
`default_nettype none
// ============================================================================
// Module      : game_link_ctl
// Description : Session controller for the two-board Fire & Water link.
//               Handles start, play and lose, and arbitrates local keys
//               against link messages from the other board.
// Revision    : 1.0 - initial release
// ============================================================================
module game_link_ctl #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] CODE_FIRE   = 8'h30,
    parameter logic [7:0] CODE_WATER  = 8'h31,
    parameter logic [7:0] CODE_LOSE   = 8'h32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_space,
    input  logic       key_enter,
    input  logic       lose_local,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       game_active,
    output logic       role,
    output logic       session_over,
    output logic       remote_lose
);

    localparam int                  c_hold_w    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_START = 3'd1,
        ST_PLAYING  = 3'd2,
        ST_TX_LOSE  = 3'd3,
        ST_OVER     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_space_d;
    logic                r_enter_d;
    logic                r_lose_d;
    logic [7:0]          r_sync1;
    logic [7:0]          r_sync2;
    logic [7:0]          r_prev;
    logic [7:0]          r_last;
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [7:0]          r_data_out;
    logic [7:0]          w_data_out_nxt;
    logic                r_data_ready;
    logic                w_data_ready_nxt;
    logic                r_game_active;
    logic                r_role;
    logic                w_role_nxt;
    logic                r_session_over;
    logic                r_remote_lose;
    logic                w_remote_lose_nxt;
    logic                w_msg_start;
    logic [7:0]          w_msg_code;

    logic w_space_rise;
    logic w_enter_rise;
    logic w_lose_rise;
    logic w_accept;
    logic w_rx_fire;
    logic w_rx_water;
    logic w_rx_lose;

    assign w_space_rise = key_space  & ~r_space_d;
    assign w_enter_rise = key_enter  & ~r_enter_d;
    assign w_lose_rise  = lose_local & ~r_lose_d;

    // A byte must sit still for two synchronized samples and be new before it counts.
    assign w_accept   = (r_sync2 == r_prev) && (r_sync2 != r_last);
    assign w_rx_fire  = w_accept && (r_sync2 == CODE_FIRE);
    assign w_rx_water = w_accept && (r_sync2 == CODE_WATER);
    assign w_rx_lose  = w_accept && (r_sync2 == CODE_LOSE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_space_d <= 1'b0;
            r_enter_d <= 1'b0;
            r_lose_d  <= 1'b0;
            r_sync1   <= 8'h00;
            r_sync2   <= 8'h00;
            r_prev    <= 8'h00;
            r_last    <= 8'h00;
        end else begin
            r_space_d <= key_space;
            r_enter_d <= key_enter;
            r_lose_d  <= lose_local;
            r_sync1   <= data_in;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            if (w_accept) begin
                r_last <= r_sync2;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_hold_nxt        = r_hold;
        w_data_out_nxt    = r_data_out;
        w_data_ready_nxt  = r_data_ready;
        w_role_nxt        = r_role;
        w_remote_lose_nxt = 1'b0;
        w_msg_start       = 1'b0;
        w_msg_code        = 8'h00;

        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    w_role_nxt  = 1'b0;
                    w_state_nxt = ST_PLAYING;
                end else if (w_rx_water) begin
                    w_role_nxt  = 1'b1;
                    w_state_nxt = ST_PLAYING;
                end else if (w_space_rise) begin
                    w_role_nxt  = 1'b1;
                    w_msg_start = 1'b1;
                    w_msg_code  = CODE_FIRE;
                    w_state_nxt = ST_TX_START;
                end else if (w_enter_rise) begin
                    w_role_nxt  = 1'b0;
                    w_msg_start = 1'b1;
                    w_msg_code  = CODE_WATER;
                    w_state_nxt = ST_TX_START;
                end
            end
            ST_TX_START, ST_TX_LOSE: begin
                if (r_hold == '0) begin
                    w_data_ready_nxt = 1'b0;
                    w_data_out_nxt   = 8'h00;
                    w_state_nxt      = (r_state == ST_TX_START) ? ST_PLAYING : ST_OVER;
                end else begin
                    w_hold_nxt = r_hold - c_hold_one;
                end
            end
            ST_PLAYING: begin
                // Local lose takes precedence so both boards agree on who lost.
                if (w_lose_rise) begin
                    w_msg_start = 1'b1;
                    w_msg_code  = CODE_LOSE;
                    w_state_nxt = ST_TX_LOSE;
                end else if (w_rx_lose) begin
                    w_remote_lose_nxt = 1'b1;
                    w_state_nxt       = ST_OVER;
                end
            end
            ST_OVER: begin
                if (w_space_rise || w_enter_rise) begin
                    w_role_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_msg_start) begin
            w_data_ready_nxt = 1'b1;
            w_data_out_nxt   = w_msg_code;
            w_hold_nxt       = c_hold_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_hold         <= '0;
            r_data_out     <= 8'h00;
            r_data_ready   <= 1'b0;
            r_game_active  <= 1'b0;
            r_role         <= 1'b0;
            r_session_over <= 1'b0;
            r_remote_lose  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold         <= w_hold_nxt;
            r_data_out     <= w_data_out_nxt;
            r_data_ready   <= w_data_ready_nxt;
            r_game_active  <= (w_state_nxt == ST_PLAYING);
            r_role         <= w_role_nxt;
            r_session_over <= (w_state_nxt == ST_OVER);
            r_remote_lose  <= w_remote_lose_nxt;
        end
    end

    assign data_out     = r_data_out;
    assign data_ready   = r_data_ready;
    assign game_active  = r_game_active;
    assign role         = r_role;
    assign session_over = r_session_over;
    assign remote_lose  = r_remote_lose;

endmodule
`default_nettype wire

// File: tb/tb_game_link_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_link_ctl
// Description : Bench for game_link_ctl: directed session scenarios followed
//               by random traffic, all compared against a session-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_link_ctl;

    localparam int HOLD = 4;

    localparam int P_IDLE     = 0;
    localparam int P_SEND_GO  = 1;
    localparam int P_PLAY     = 2;
    localparam int P_SEND_END = 3;
    localparam int P_OVER     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_space;
    logic       key_enter;
    logic       lose_local;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_ready;
    logic       game_active;
    logic       role;
    logic       session_over;
    logic       remote_lose;

    int n_tests = 0;
    int n_fail  = 0;

    game_link_ctl #(
        .HOLD_CYCLES (HOLD),
        .CODE_FIRE   (8'h30),
        .CODE_WATER  (8'h31),
        .CODE_LOSE   (8'h32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_space    (key_space),
        .key_enter    (key_enter),
        .lose_local   (lose_local),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .game_active  (game_active),
        .role         (role),
        .session_over (session_over),
        .remote_lose  (remote_lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Session model: samples of data_in over the last three edges, the last
    // accepted byte, and the session phase with a countdown of visible message cycles.
    int         m_phase;
    int         m_tx_left;
    logic [7:0] m_tx_code;
    logic [7:0] m_s1, m_s2, m_s3, m_last;
    bit         m_role, m_rlose, m_pks, m_pke, m_pll, m_valid;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        bit srise, erise, lrise;
        int ev;
        if (!rst) begin
            m_phase = P_IDLE; m_tx_left = 0; m_tx_code = 8'h00;
            m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00; m_last = 8'h00;
            m_role = 1'b0; m_rlose = 1'b0;
            m_pks = 1'b0; m_pke = 1'b0; m_pll = 1'b0;
            m_valid = 1'b1;
        end else begin
            ev = 0;
            if (m_s2 == m_s3 && m_s2 != m_last) begin
                m_last = m_s2;
                if (m_s2 == 8'h30) ev = 1;
                else if (m_s2 == 8'h31) ev = 2;
                else if (m_s2 == 8'h32) ev = 3;
            end
            srise = key_space && !m_pks;
            erise = key_enter && !m_pke;
            lrise = lose_local && !m_pll;
            m_rlose = 1'b0;
            if (m_phase == P_IDLE) begin
                if (ev == 1) begin m_role = 1'b0; m_phase = P_PLAY; end
                else if (ev == 2) begin m_role = 1'b1; m_phase = P_PLAY; end
                else if (srise) begin m_role = 1'b1; m_tx_code = 8'h30; m_tx_left = HOLD; m_phase = P_SEND_GO; end
                else if (erise) begin m_role = 1'b0; m_tx_code = 8'h31; m_tx_left = HOLD; m_phase = P_SEND_GO; end
            end else if (m_phase == P_SEND_GO || m_phase == P_SEND_END) begin
                if (m_tx_left == 1) begin
                    m_tx_left = 0;
                    m_phase = (m_phase == P_SEND_GO) ? P_PLAY : P_OVER;
                end else begin
                    m_tx_left--;
                end
            end else if (m_phase == P_PLAY) begin
                if (lrise) begin m_tx_code = 8'h32; m_tx_left = HOLD; m_phase = P_SEND_END; end
                else if (ev == 3) begin m_rlose = 1'b1; m_phase = P_OVER; end
            end else if (m_phase == P_OVER) begin
                if (srise || erise) begin m_role = 1'b0; m_phase = P_IDLE; end
            end
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = data_in;
            m_pks = key_space; m_pke = key_enter; m_pll = lose_local;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_data_out",     data_out,     (m_tx_left > 0) ? m_tx_code : 8'h00);
            chk("m_data_ready",   data_ready,   8'(m_tx_left > 0));
            chk("m_game_active",  game_active,  8'(m_phase == P_PLAY));
            chk("m_role",         role,         8'(m_role));
            chk("m_session_over", session_over, 8'(m_phase == P_OVER));
            chk("m_remote_lose",  remote_lose,  8'(m_rlose));
        end
    end

    function automatic logic [7:0] pick_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 4);
        case (r)
            0: b = 8'h00;
            1: b = 8'h30;
            2: b = 8'h31;
            3: b = 8'h32;
            default: b = 8'($urandom);
        endcase
        return b;
    endfunction

    initial begin
        logic [7:0] saved;
        bit glitch;
        rst = 1'b0; key_space = 1'b1; key_enter = 1'b1; lose_local = 1'b0; data_in = 8'h31;
        cyc(3);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_ready", data_ready, 8'h00);
        chk("rst_active", game_active, 8'h00);
        chk("rst_over", session_over, 8'h00);
        rst = 1'b1; key_space = 1'b0; key_enter = 1'b0;
        cyc(3); chk("rx_water_early", game_active, 8'h00);
        cyc(1); chk("rx_water_active", game_active, 8'h01); chk("rx_water_role", role, 8'h01);

        data_in = 8'h00; cyc(6);
        data_in = 8'h32; cyc(3); chk("rlose_early", remote_lose, 8'h00);
        cyc(1);
        chk("rlose_pulse", remote_lose, 8'h01); chk("rlose_over", session_over, 8'h01);
        chk("rlose_inactive", game_active, 8'h00); chk("rlose_no_tx", data_ready, 8'h00);
        cyc(1); chk("rlose_one_cycle", remote_lose, 8'h00);

        key_enter = 1'b1; cyc(1);
        chk("rearm_over", session_over, 8'h00); chk("rearm_role", role, 8'h00);
        key_enter = 1'b0; cyc(2); key_enter = 1'b1; cyc(1);
        chk("water_tx_ready", data_ready, 8'h01); chk("water_tx_code", data_out, 8'h31);
        cyc(3); chk("water_tx_last", data_ready, 8'h01);
        cyc(1);
        chk("water_tx_done", data_ready, 8'h00); chk("water_active", game_active, 8'h01);
        chk("water_role", role, 8'h00);
        key_enter = 1'b0;

        data_in = 8'h00; cyc(6);
        data_in = 8'h32; cyc(3); lose_local = 1'b1; cyc(1);
        chk("llose_code", data_out, 8'h32); chk("llose_no_rlose", remote_lose, 8'h00);
        chk("llose_inactive", game_active, 8'h00);
        cyc(4); chk("llose_done", data_ready, 8'h00); chk("llose_over", session_over, 8'h01);
        lose_local = 1'b0;

        key_space = 1'b1; cyc(1); key_space = 1'b0;
        data_in = 8'h31; cyc(1); data_in = 8'h32; cyc(8);
        chk("glitch_ignored", game_active, 8'h00);

        key_space = 1'b1; cyc(1);
        chk("fire_tx_code", data_out, 8'h30); chk("fire_tx_ready", data_ready, 8'h01);
        cyc(4);
        chk("fire_tx_done", data_out, 8'h00); chk("fire_role", role, 8'h01);
        cyc(100); chk("held_key_no_tx", data_ready, 8'h00);
        lose_local = 1'b1; cyc(6); lose_local = 1'b0;
        key_space = 1'b0; key_enter = 1'b1; cyc(1); key_enter = 1'b0; cyc(1);

        key_space = 1'b1; key_enter = 1'b1; cyc(1);
        chk("both_keys_code", data_out, 8'h30); chk("both_keys_role", role, 8'h01);
        key_space = 1'b0; key_enter = 1'b0; cyc(4);
        lose_local = 1'b1; cyc(6); lose_local = 1'b0;
        key_space = 1'b1; cyc(1); key_space = 1'b0;

        data_in = 8'h31; cyc(3); key_enter = 1'b1; cyc(1);
        chk("rx_beats_key_tx", data_ready, 8'h00); chk("rx_beats_key_active", game_active, 8'h01);
        chk("rx_beats_key_role", role, 8'h01);
        key_enter = 1'b0;

        rst = 1'b0; data_in = 8'h00; cyc(1); rst = 1'b1; cyc(1);
        key_enter = 1'b1; cyc(2); chk("abort_pre", data_ready, 8'h01);
        rst = 1'b0; cyc(1); chk("abort_ready", data_ready, 8'h00); chk("abort_out", data_out, 8'h00);
        rst = 1'b1; key_enter = 1'b0; cyc(2);

        glitch = 1'b0; saved = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) key_space = ~key_space;
            if ($urandom_range(0, 11) == 0) key_enter = ~key_enter;
            if ($urandom_range(0, 9) == 0) lose_local = ~lose_local;
            if (glitch) begin
                data_in = saved; glitch = 1'b0;
            end else begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 6) data_in = pick_byte();
                else if (r < 8) begin saved = data_in; data_in = pick_byte(); glitch = 1'b1; end
            end
            rst = ($urandom_range(0, 299) != 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
